mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - instruction fetch / data load-store sequencer toward a req/ack memory port
// Latches the access at start, aligns byte lanes little-endian, and bounds the ack wait with TIMEOUT.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        IRWr,
  input  logic        IorD,
  input  logic [5:0]  op,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic [31:0] IR,
  output logic [31:0] MDR,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, IFETCH, DLOAD, DSTORE, FINISH} state_t;

  state_t         state, state_nx;
  logic [1:0]     size_q;
  logic           sext_q;
  logic [31:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [CW-1:0]  wait_cnt;
  logic           err_q;

  logic           is_load, is_store, is_word, is_half, misalign;
  logic           accept, reject, timeout;
  logic [31:0]    start_addr, lane, load_val;

  // op[1:0] encodes size (00 byte, 01 half, 11 word); op[2] clear means sign-extend
  always_comb begin
    is_load    = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    is_store   = op inside {6'h28, 6'h29, 6'h2B};
    is_word    = (op[1:0] == 2'b11);
    is_half    = (op[1:0] == 2'b01);
    start_addr = IRWr ? pc : addr;
    if (IRWr || is_word) misalign = |start_addr[1:0];
    else if (is_half)    misalign = start_addr[0];
    else                 misalign = 1'b0;
    accept = start && (state == IDLE) && !misalign &&
             (IRWr || (IorD && (is_load || is_store)));
    reject = start && (state == IDLE) && !accept;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (IRWr)         state_nx = IFETCH;
          else if (is_load) state_nx = DLOAD;
          else              state_nx = DSTORE;
        end
      end
      IFETCH, DLOAD, DSTORE: begin
        if (m_ack) begin
          state_nx = FINISH;
        end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    m_req   = (state == IFETCH) || (state == DLOAD) || (state == DSTORE);
    m_we    = (state == DSTORE);
    busy    = (state != IDLE);
    done    = (state == FINISH);
    err     = err_q;
    m_addr  = {addr_q[31:2], 2'b00};
    m_be    = 4'b0000;
    m_wdata = 32'h0;
    if (state == DSTORE) begin
      case (size_q)
        2'b00: begin
          m_be    = 4'b0001 << addr_q[1:0];
          m_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          m_be    = addr_q[1] ? 4'b1100 : 4'b0011;
          m_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          m_be    = 4'b1111;
          m_wdata = wdata_q;
        end
      endcase
    end
  end

  always_comb begin
    lane = m_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{sext_q & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{16{sext_q & lane[15]}}, lane[15:0]};
      default: load_val = m_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      size_q   <= 2'b00;
      sext_q   <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      IR       <= 32'h0;
      MDR      <= 32'h0;
    end else begin
      err_q <= reject || timeout;
      if (accept) begin
        size_q   <= op[1:0];
        sext_q   <= !op[2];
        addr_q   <= start_addr;
        wdata_q  <= wdata;
        wait_cnt <= '0;
      end else if (m_req && !m_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == IFETCH && m_ack) IR  <= m_rdata;
      if (state == DLOAD && m_ack)  MDR <= load_val;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
// A word-addressed memory model and size/offset arithmetic supply every expected value.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        IRWr = 1'b0;
  logic        IorD = 1'b0;
  logic [5:0]  op = 6'h0;
  logic [31:0] pc = 32'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ack = 1'b0;
  logic        m_req, m_we, busy, done, err;
  logic [31:0] m_addr, m_wdata, IR, MDR;
  logic [3:0]  m_be;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .IRWr(IRWr), .IorD(IorD), .op(op),
    .pc(pc), .addr(addr), .wdata(wdata), .m_req(m_req), .m_we(m_we),
    .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_ack(m_ack), .IR(IR), .MDR(MDR), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_ir = 32'h0;
  logic [31:0] exp_mdr = 32'h0;
  logic [5:0]  op_list [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    logic [31:0] wa = a & ~32'h3;
    if (!mem.exists(wa)) mem[wa] = $urandom;
    return mem[wa];
  endfunction

  function automatic int op_size(input logic [5:0] o);
    case (o)
      6'h20, 6'h24, 6'h28: return 1;
      6'h21, 6'h25, 6'h29: return 2;
      6'h23, 6'h2B:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [5:0] o);
    return o inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  endfunction

  // 0 rejected, 1 fetch, 2 load, 3 store
  function automatic int classify(input bit irwr, input bit iord, input logic [5:0] o,
                                  input logic [31:0] p, input logic [31:0] a);
    if (irwr) return (p % 4 == 0) ? 1 : 0;
    if (!iord || op_size(o) == 0) return 0;
    if (a % op_size(o) != 0) return 0;
    return op_load(o) ? 2 : 3;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [31:0] a,
                                             input logic [5:0] o);
    int sz = op_size(o);
    logic [31:0] mask, v;
    if (sz == 4) return word;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (word >> (8 * (a % 4))) & mask;
    if ((o == 6'h20 || o == 6'h21) && ((v >> (8 * sz - 1)) & 1)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] store_be(input logic [31:0] a, input logic [5:0] o);
    logic [3:0] be = 4'b0;
    for (int k = 0; k < 4; k++)
      if (k >= a % 4 && k < a % 4 + op_size(o)) be[k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [5:0] o);
    logic [31:0] d = 32'h0;
    for (int k = 0; k < 4; k++) d[8*k +: 8] = wd[8*(k % op_size(o)) +: 8];
    return d;
  endfunction

  // Called just after a falling edge; returns just after a falling edge. delay<0 never acks.
  task automatic run_access(input bit irwr, input bit iord, input logic [5:0] o,
                            input logic [31:0] p, input logic [31:0] a, input logic [31:0] wd,
                            input int delay, input bit intrude);
    int kind = classify(irwr, iord, o, p, a);
    logic [31:0] ea = irwr ? p : a;
    logic [31:0] word = rd_word(ea);
    int bad = 0;
    start = 1'b1; IRWr = irwr; IorD = iord; op = o; pc = p; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0; IRWr = 1'b0; IorD = 1'b0;
    op = 6'($urandom); pc = $urandom; addr = $urandom; wdata = $urandom;
    if (kind == 0) begin
      check("rej_err", 32'(err), 32'd1);
      check("rej_req", 32'(m_req), 32'd0);
      check("rej_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("rej_err_clr", 32'(err), 32'd0);
      check("rej_mdr", MDR, exp_mdr);
      check("rej_ir", IR, exp_ir);
      return;
    end
    check("addr", m_addr, ea & ~32'h3);
    check("we", 32'(m_we), (kind == 3) ? 32'd1 : 32'd0);
    if (kind == 3) begin
      check("st_be", 32'(m_be), 32'(store_be(ea, o)));
      check("st_data", m_wdata, store_data(wd, o));
    end
    if (delay < 0) begin
      for (int i = 0; i < TMO; i++) begin
        if (m_req !== 1'b1 || done !== 1'b0 || err !== 1'b0) bad++;
        @(negedge clk);
      end
      check("tmo_req_held", bad, 0);
      check("tmo_req_drop", 32'(m_req), 32'd0);
      check("tmo_err", 32'(err), 32'd1);
      check("tmo_done", 32'(done), 32'd0);
      check("tmo_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("tmo_err_clr", 32'(err), 32'd0);
      check("tmo_ir", IR, exp_ir);
      check("tmo_mdr", MDR, exp_mdr);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      if (m_req !== 1'b1 || done !== 1'b0 || busy !== 1'b1 || m_addr !== (ea & ~32'h3)) bad++;
      if (intrude && i == 0) begin
        start = 1'b1; IRWr = 1'b1; IorD = 1'b1; pc = $urandom & 32'hFFC;
      end
      @(negedge clk);
      start = 1'b0; IRWr = 1'b0; IorD = 1'b0;
    end
    check("wait_hold", bad, 0);
    check("req_at_ack", 32'(m_req), 32'd1);
    m_ack = 1'b1;
    m_rdata = (kind == 3) ? $urandom : word;
    @(negedge clk);
    m_ack = 1'b0;
    m_rdata = $urandom;
    if (kind == 1) exp_ir = word;
    if (kind == 2) exp_mdr = load_value(word, ea, o);
    if (kind == 3) begin
      logic [3:0] be = store_be(ea, o);
      logic [31:0] sd = store_data(wd, o);
      for (int k = 0; k < 4; k++) if (be[k]) word[8*k +: 8] = sd[8*k +: 8];
      mem[ea & ~32'h3] = word;
    end
    check("fin_done", 32'(done), 32'd1);
    check("fin_req", 32'(m_req), 32'd0);
    check("fin_be", 32'(m_be), 32'd0);
    check("fin_wdata", m_wdata, 32'd0);
    check("fin_ir", IR, exp_ir);
    check("fin_mdr", MDR, exp_mdr);
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_req", 32'(m_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", {29'd0, done, err, m_we}, 32'd0);
    check("rst_ir", IR, 32'd0);
    check("rst_mdr", MDR, 32'd0);
    check("rst_addr", m_addr, 32'd0);
    check("rst_be_wd", m_wdata | 32'(m_be), 32'd0);
    rstn = 1'b1;

    mem[32'h100] = 32'h8C220004;
    run_access(1'b1, 1'b0, 6'h0, 32'h100, 32'h0, 32'h0, 3, 1'b0);
    check("dir_fetch_ir", IR, 32'h8C220004);
    mem[32'h200] = 32'h80FF7F01;
    run_access(1'b0, 1'b1, 6'h20, 32'h0, 32'h203, 32'h0, 1, 1'b0);
    check("dir_lb", MDR, 32'hFFFFFF80);
    run_access(1'b0, 1'b1, 6'h24, 32'h0, 32'h203, 32'h0, 0, 1'b0);
    check("dir_lbu", MDR, 32'h00000080);
    run_access(1'b0, 1'b1, 6'h29, 32'h0, 32'h302, 32'h1234ABCD, 2, 1'b0);
    run_access(1'b0, 1'b1, 6'h23, 32'h0, 32'h401, 32'h0, 0, 1'b0);
    run_access(1'b1, 1'b1, 6'h2B, 32'h10, 32'h401, 32'h0, 1, 1'b0);
    run_access(1'b0, 1'b0, 6'h23, 32'h0, 32'h400, 32'h0, 1, 1'b0);
    run_access(1'b0, 1'b1, 6'h22, 32'h0, 32'h400, 32'h0, 1, 1'b0);
    run_access(1'b0, 1'b1, 6'h23, 32'h0, 32'h404, 32'h0, -1, 1'b0);
    run_access(1'b0, 1'b1, 6'h21, 32'h0, 32'h406, 32'h0, TMO - 1, 1'b1);

    m_ack = 1'b1; m_rdata = $urandom;
    @(negedge clk); @(negedge clk);
    m_ack = 1'b0;
    check("idle_ack_busy", 32'(busy), 32'd0);
    check("idle_ack_done", 32'(done), 32'd0);
    check("idle_ack_ir", IR, exp_ir);

    start = 1'b1; IorD = 1'b1; op = 6'h2B; addr = 32'h500; wdata = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0; IorD = 1'b0;
    check("st_req_before_rst", 32'(m_req), 32'd1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async_rst_req", 32'(m_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_be", 32'(m_be), 32'd0);
    check("async_rst_ir_mdr", IR | MDR, 32'd0);
    exp_ir = 32'h0; exp_mdr = 32'h0;
    @(negedge clk);
    rstn = 1'b1;
    run_access(1'b1, 1'b0, 6'h0, 32'h104, 32'h0, 32'h0, 0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      bit irwr = ($urandom % 4 == 0);
      bit iord = ($urandom % 8 != 0);
      logic [5:0] o = ($urandom % 10 == 0) ? 6'($urandom) : op_list[$urandom % 8];
      logic [31:0] p = $urandom_range(0, 1023);
      logic [31:0] a = $urandom_range(0, 1023);
      int d = $urandom % 5;
      if ($urandom % 4 != 0) p = p & ~32'h3;
      if ($urandom % 3 == 0) a = a & ~32'h3;
      run_access(irwr, iord, o, p, a, $urandom, d, (d > 0) && ($urandom % 4 == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
